immediate_decode_stage: RTL and testbench

IMMEDIATE_DECODE_STAGE -- requirements
Module: immediate_decode_stage

---
 rtl/immediate_decode_stage.sv | 152 +++++++++++++++
 tb/tb_immediate_decode_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/immediate_decode_stage.sv
// RV immediate decoder: classifies each incoming instruction and extends its immediate,
// then buffers the decoded result in a 2-entry FIFO whose head drives the outputs.
module immediate_decode_stage #(
  parameter int XLEN                 = 32,
  parameter bit ENABLE_CSR_IMMEDIATE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_immediate,
  output logic [2:0]      out_format,
  output logic            out_illegal,
  output logic [31:0]     out_instruction
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("immediate_decode_stage: XLEN must be 32 or 64");
    end
  endgenerate

  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_Z = 3'd6;

  logic [31:0]     imm32;
  logic [2:0]      dec_format;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_immediate;

  // Every immediate is first built as a 32-bit signed value; zimm has bit 31 clear,
  // so widening by sign extension zero-extends it for free.
  always_comb begin
    imm32       = '0;
    dec_format  = FMT_R;
    dec_illegal = 1'b1;
    if (in_instruction[1:0] == 2'b11) begin
      case (in_instruction[6:0])
        7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
          dec_format  = FMT_I;
          dec_illegal = 1'b0;
          imm32       = {{20{in_instruction[31]}}, in_instruction[31:20]};
        end
        7'b0011011: begin
          if (IS_RV64) begin
            dec_format  = FMT_I;
            dec_illegal = 1'b0;
            imm32       = {{20{in_instruction[31]}}, in_instruction[31:20]};
          end
        end
        7'b0100011: begin
          dec_format  = FMT_S;
          dec_illegal = 1'b0;
          imm32       = {{20{in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
        end
        7'b1100011: begin
          dec_format  = FMT_B;
          dec_illegal = 1'b0;
          imm32       = {{19{in_instruction[31]}}, in_instruction[31], in_instruction[7],
                         in_instruction[30:25], in_instruction[11:8], 1'b0};
        end
        7'b0010111, 7'b0110111: begin
          dec_format  = FMT_U;
          dec_illegal = 1'b0;
          imm32       = {in_instruction[31:12], 12'b0};
        end
        7'b1101111: begin
          dec_format  = FMT_J;
          dec_illegal = 1'b0;
          imm32       = {{11{in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                         in_instruction[20], in_instruction[30:21], 1'b0};
        end
        7'b0110011: begin
          dec_illegal = 1'b0;
        end
        7'b0111011: begin
          if (IS_RV64) dec_illegal = 1'b0;
        end
        7'b1110011: begin
          if (ENABLE_CSR_IMMEDIATE) begin
            dec_format  = FMT_Z;
            dec_illegal = 1'b0;
            imm32       = {27'b0, in_instruction[19:15]};
          end
        end
        default: ;
      endcase
    end
  end

  generate
    if (XLEN == 64) begin : g_wide
      assign dec_immediate = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign dec_immediate = imm32[XLEN-1:0];
    end
  endgenerate

  logic [1:0] count_reg;
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic       push;
  logic       pop;

  assign in_ready  = (count_reg < 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: every read is masked by out_valid, which reset clears.
  logic [XLEN-1:0] imm_mem [2];
  logic [2:0]      fmt_mem [2];
  logic            ill_mem [2];
  logic [31:0]     ins_mem [2];

  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem[wr_ptr_reg] <= dec_immediate;
      fmt_mem[wr_ptr_reg] <= dec_format;
      ill_mem[wr_ptr_reg] <= dec_illegal;
      ins_mem[wr_ptr_reg] <= in_instruction;
    end
  end

  assign out_immediate   = out_valid ? imm_mem[rd_ptr_reg] : '0;
  assign out_format      = out_valid ? fmt_mem[rd_ptr_reg] : 3'd0;
  assign out_illegal     = out_valid ? ill_mem[rd_ptr_reg] : 1'b0;
  assign out_instruction = out_valid ? ins_mem[rd_ptr_reg] : 32'd0;

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Bench for immediate_decode_stage: an RV32 (CSR zimm on) and an RV64 (CSR zimm off) copy
// share stimulus and are compared each cycle against a queue-based reference model.
module tb_immediate_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instruction;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [2:0]  out_format32;
  logic [31:0] out_immediate32, out_instruction32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [2:0]  out_format64;
  logic [63:0] out_immediate64;
  logic [31:0] out_instruction64;

  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  immediate_decode_stage #(.XLEN(32), .ENABLE_CSR_IMMEDIATE(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instruction(in_instruction), .out_valid(out_valid32), .out_ready(out_ready),
    .out_immediate(out_immediate32), .out_format(out_format32),
    .out_illegal(out_illegal32), .out_instruction(out_instruction32)
  );

  immediate_decode_stage #(.XLEN(64), .ENABLE_CSR_IMMEDIATE(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instruction(in_instruction), .out_valid(out_valid64), .out_ready(out_ready),
    .out_immediate(out_immediate64), .out_format(out_format64),
    .out_illegal(out_illegal64), .out_instruction(out_instruction64)
  );

  // {valid, ready, illegal, format, immediate(64, zero-padded for RV32), instruction}
  wire [101:0] act32 = {out_valid32, in_ready32, out_illegal32, out_format32,
                        32'b0, out_immediate32, out_instruction32};
  wire [101:0] act64 = {out_valid64, in_ready64, out_illegal64, out_format64,
                        out_immediate64, out_instruction64};

  // Reference: decode the queue head straight from the ISA immediate rules.
  function automatic logic [101:0] model_word(bit is64, bit csr);
    logic [31:0] i;
    longint      imm;
    logic [2:0]  f;
    bit          ill;
    if (q.size() == 0) return {1'b0, 1'b1, 100'b0};
    i = q[0]; f = 3'd0; imm = 0; ill = 1'b1;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'h03, 7'h13, 7'h67, 7'h0F: begin f = 3'd1; ill = 0; imm = longint'($signed(i[31:20])); end
        7'h1B: if (is64) begin f = 3'd1; ill = 0; imm = longint'($signed(i[31:20])); end
        7'h23: begin f = 3'd2; ill = 0; imm = longint'($signed({i[31:25], i[11:7]})); end
        7'h63: begin
          f = 3'd3; ill = 0;
          imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        end
        7'h17, 7'h37: begin f = 3'd4; ill = 0; imm = longint'($signed(i[31:12])) * 4096; end
        7'h6F: begin
          f = 3'd5; ill = 0;
          imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        end
        7'h33: ill = 0;
        7'h3B: if (is64) ill = 0;
        7'h73: if (csr) begin f = 3'd6; ill = 0; imm = longint'(i[19:15]); end
        default: ;
      endcase
    end
    if (!is64) imm = {32'b0, imm[31:0]};
    return {1'b1, (q.size() < 2), ill, f, imm, i};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [16] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h1B, 7'h23, 7'h63, 7'h17,
                             7'h37, 7'h6F, 7'h33, 7'h3B, 7'h73, 7'h7F, 7'h5B, 7'h12};
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 15)];
    return w;
  endfunction

  // Advance one clock, updating the model with what the stage accepts and emits.
  task automatic cycle();
    bit push = in_valid && (q.size() < 2);
    bit pop  = (q.size() != 0) && out_ready;
    logic [31:0] w = in_instruction;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(w);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [101:0] e32, e64;
    rst_n = 1'b1; in_valid = 1'b0; in_instruction = 32'h0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    in_valid = 1'b1; in_instruction = 32'h00500093;
    repeat (2) @(negedge clk);
    e32 = model_word(0, 1); e64 = model_word(1, 0);
    checks++;
    if (act32 !== e32 || act64 !== e64) begin
      errors++;
      $display("FAIL reset_hold x32 got %h exp %h x64 got %h exp %h", act32, e32, act64, e64);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    cycle();
    e32 = model_word(0, 1); e64 = model_word(1, 0);
    checks++;
    if (act32 !== e32 || act64 !== e64) begin
      errors++;
      $display("FAIL reset_release x32 got %h exp %h x64 got %h exp %h", act32, e32, act64, e64);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vec [9] = '{32'hFE000EE3, 32'h800002B7, 32'h0007D073, 32'h0000007F,
                             32'hFFF10093, 32'h80A12423, 32'h8000006F, 32'h40B50533,
                             32'h8005051B};
    logic [101:0] e32, e64;
    out_ready = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      in_valid = (k < 9);
      if (k < 9) in_instruction = vec[k];
      cycle();
      e32 = model_word(0, 1); e64 = model_word(1, 0);
      checks++;
      if (act32 !== e32 || act64 !== e64) begin
        errors++;
        $display("FAIL directed[%0d] x32 got %h exp %h x64 got %h exp %h", k, act32, e32, act64, e64);
      end else
        $display("directed[%0d] instr %h fmt %0d imm64 %h", k, e64[31:0], e64[98:96], e64[95:32]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] abc [3] = '{32'h00C58593, 32'hFE000EE3, 32'h12345037};
    logic [101:0] e32, e64;
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = (k < 7);
      in_instruction = abc[(k < 2) ? k : 2];
      if (k == 5) out_ready = 1'b1;
      cycle();
      e32 = model_word(0, 1); e64 = model_word(1, 0);
      checks++;
      if (act32 !== e32 || act64 !== e64) begin
        errors++;
        $display("FAIL backpressure[%0d] x32 got %h exp %h x64 got %h exp %h", k, act32, e32, act64, e64);
      end else
        $display("backpressure[%0d] valid %0d ready %0d head %h", k, e32[101], e32[100], e32[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [101:0] e32, e64;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      in_valid = (k < 8);
      in_instruction = rand_instr();
      cycle();
      e32 = model_word(0, 1); e64 = model_word(1, 0);
      checks++;
      if (act32 !== e32 || act64 !== e64 || (k < 8 && !(out_valid32 && in_ready32))) begin
        errors++;
        $display("FAIL stream[%0d] x32 got %h exp %h x64 got %h exp %h", k, act32, e32, act64, e64);
      end else
        $display("stream[%0d] head %h", k, e32[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [101:0] e32, e64;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instruction = 32'h00000013; cycle();
    in_instruction = 32'h00000063; cycle();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 q.delete();
    e32 = model_word(0, 1); e64 = model_word(1, 0);
    checks++;
    if (act32 !== e32 || act64 !== e64) begin
      errors++;
      $display("FAIL mid_reset_drop x32 got %h exp %h x64 got %h exp %h", act32, e32, act64, e64);
    end
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_instruction = 32'hABCDE0B7;
    for (int k = 0; k < 2; k++) begin
      cycle();
      e32 = model_word(0, 1); e64 = model_word(1, 0);
      checks++;
      if (act32 !== e32 || act64 !== e64) begin
        errors++;
        $display("FAIL mid_reset_after[%0d] x32 got %h exp %h x64 got %h exp %h", k, act32, e32, act64, e64);
      end else
        $display("mid_reset_after[%0d] valid %0d head %h", k, e32[101], e32[31:0]);
      in_valid = 1'b0; out_ready = 1'b1;
    end
  endtask

  task automatic test_random();
    logic [101:0] e32, e64;
    for (int k = 0; k < 300; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instruction = rand_instr();
      cycle();
      e32 = model_word(0, 1); e64 = model_word(1, 0);
      checks++;
      if (act32 !== e32 || act64 !== e64) begin
        errors++;
        $display("FAIL random[%0d] x32 got %h exp %h x64 got %h exp %h", k, act32, e32, act64, e64);
      end
    end
    $display("random: 300 cycles compared");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
